// File: rtl/hazard_scoreboard.sv
// Pipeline hazard control: EX-stage forwarding, load-use stall, branch flush,
// and a per-register scoreboard for long-latency units that write back out of band.
module hazard_scoreboard #(
    parameter int ADDR_WIDTH      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  IsLongD,
    input  logic [ADDR_WIDTH-1:0] Rs1E,
    input  logic [ADDR_WIDTH-1:0] Rs2E,
    input  logic [ADDR_WIDTH-1:0] RdE,
    input  logic                  RegWriteE,
    input  logic                  IssueLongE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LongDoneValid,
    input  logic [ADDR_WIDTH-1:0] LongDoneRd,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  Busy,
    output logic                  ErrorSticky
);

    localparam int                   NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic cnt_full, cnt_empty, cnt_inc, cnt_dec;
    logic load_stall, sb_stall, stall, issue_hit;

    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic [ADDR_WIDTH-1:0] rd_m,
        input logic                  we_m,
        input logic [ADDR_WIDTH-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && rd_m != '0 && rd_m == rs)
            sel = 2'b10;
        else if (we_w && rd_w != '0 && rd_w == rs)
            sel = 2'b01;
        return sel;
    endfunction

    // RegWriteE does not influence any control here; the main-pipe result is
    // forwarded once it reaches Memory/Writeback.
    logic unused_ok;
    assign unused_ok = RegWriteE;

    always_comb begin
        cnt_full  = (cnt_q == CNT_MAX);
        cnt_empty = (cnt_q == '0);
        // A completion on the same edge frees the slot the new issue takes.
        cnt_inc   = IssueLongE && (!cnt_full || LongDoneValid);
        cnt_dec   = LongDoneValid && !cnt_empty;

        pending_d = pending_q;
        if (LongDoneValid)
            pending_d[LongDoneRd] = 1'b0;
        if (IssueLongE && RdE != '0)
            pending_d[RdE] = 1'b1;
        pending_d[0] = 1'b0;

        cnt_d = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q
              | (LongDoneValid && cnt_empty)
              | (IssueLongE && cnt_full && !LongDoneValid);
    end

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

        load_stall = (ResultSrcE == 2'b01) && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);

        // Catches a dependency on the bit being set on this very edge.
        issue_hit = IssueLongE && RdE != '0
                  && (RdE == Rs1D || RdE == Rs2D || (RegWriteD && RdE == RdD));

        sb_stall = pending_q[Rs1D] || pending_q[Rs2D]
                || (RegWriteD && pending_q[RdD])
                || (IsLongD && cnt_full)
                || issue_hit;

        stall = load_stall || sb_stall;

        if (PCSrcE) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = stall;
            StallD = stall;
            FlushD = 1'b0;
            FlushE = stall;
        end

        Busy        = |pending_q;
        ErrorSticky = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: the driver queues hand-computed expected outputs per cycle,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_hazard_scoreboard;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
    logic          RegWriteD, IsLongD, RegWriteE, IssueLongE, PCSrcE;
    logic          RegWriteM, RegWriteW, LongDoneValid;
    logic [1:0]    ResultSrcE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE, Busy, ErrorSticky;

    hazard_scoreboard #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .IsLongD(IsLongD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .IssueLongE(IssueLongE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .Busy(Busy), .ErrorSticky(ErrorSticky)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, FlushD, FlushE}
    localparam logic [3:0] CTL_NONE  = 4'b0000;
    localparam logic [3:0] CTL_STALL = 4'b1101;
    localparam logic [3:0] CTL_BR    = 4'b0011;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [9:0] act;
    assign act = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, Busy, ErrorSticky};

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got fa/fb/ctl/busy/err=%b required %b", e.name, act, e.exp);
            end else begin
                $display("[%0t] %-14s ok  %b", $time, e.name, act);
            end
        end
    end

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; IsLongD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0; IssueLongE = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LongDoneValid = 1'b0; LongDoneRd = '0;
    endtask

    task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] ctl, input logic busy, input logic err);
        exp_t e;
        e.name = name;
        e.exp  = {fa, fb, ctl, busy, err};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle();
        #1;
        expect_out("reset", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        expect_out("idle", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();

        // Forwarding
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd6;
        expect_out("fwd_mem_pri", 2'b10, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        RdM = 5'd0;
        expect_out("fwd_wb", 2'b01, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        idle();
        RegWriteM = 1'b1; RdM = 5'd6; Rs2E = 5'd6; RegWriteW = 1'b1; RdW = 5'd0; Rs1E = 5'd0;
        expect_out("fwd_b_mem_x0", 2'b00, 2'b10, CTL_NONE, 1'b0, 1'b0);
        tick();
        RegWriteM = 1'b0; RdW = 5'd6;
        expect_out("fwd_b_wb", 2'b00, 2'b01, CTL_NONE, 1'b0, 1'b0);
        tick();

        // Load-use and branch priority
        idle();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        expect_out("load_use", 2'b00, 2'b00, CTL_STALL, 1'b0, 1'b0);
        tick();
        PCSrcE = 1'b1;
        expect_out("branch_prio", 2'b00, 2'b00, CTL_BR, 1'b0, 1'b0);
        tick();
        idle();
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        expect_out("load_x0", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        ResultSrcE = 2'b00; RdE = 5'd7; Rs2D = 5'd7;
        expect_out("non_load", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();

        // Scoreboard RAW / WAW on x9
        idle();
        IssueLongE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        expect_out("raw_issue_cyc", 2'b00, 2'b00, CTL_STALL, 1'b0, 1'b0);
        tick();
        idle(); Rs1D = 5'd9;
        expect_out("raw_pending", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); Rs1D = 5'd1; RegWriteD = 1'b1; RdD = 5'd9;
        expect_out("waw_pending", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); Rs1D = 5'd9; LongDoneValid = 1'b1; LongDoneRd = 5'd9;
        expect_out("raw_done_cyc", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); Rs1D = 5'd9;
        expect_out("raw_released", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();

        // Occupancy limit
        for (int i = 1; i <= 3; i++) begin
            idle(); IssueLongE = 1'b1; RdE = AW'(i);
            expect_out($sformatf("occ_issue%0d", i), 2'b00, 2'b00, CTL_NONE, (i > 1), 1'b0);
            tick();
        end
        idle(); IssueLongE = 1'b1; RdE = 5'd4; IsLongD = 1'b1;
        expect_out("occ_issue4", 2'b00, 2'b00, CTL_NONE, 1'b1, 1'b0);
        tick();
        idle(); IsLongD = 1'b1;
        expect_out("occ_full", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); IsLongD = 1'b1; IssueLongE = 1'b1; RdE = 5'd5; LongDoneValid = 1'b1; LongDoneRd = 5'd1;
        expect_out("occ_swap", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); IsLongD = 1'b1;
        expect_out("occ_still_full", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); IsLongD = 1'b1; LongDoneValid = 1'b1; LongDoneRd = 5'd2;
        expect_out("occ_done_cyc", 2'b00, 2'b00, CTL_STALL, 1'b1, 1'b0);
        tick();
        idle(); IsLongD = 1'b1;
        expect_out("occ_free", 2'b00, 2'b00, CTL_NONE, 1'b1, 1'b0);
        tick();

        // Asynchronous reset with x3, x4, x5 pending, no clock edge in between
        idle();
        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        rst = 1'b1;

        // Counter was cleared: a done now underflows
        idle(); LongDoneValid = 1'b1; LongDoneRd = 5'd3;
        expect_out("underflow_cyc", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        idle();
        expect_out("err_set", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b1);
        tick();
        expect_out("err_held", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b1);
        tick();

        // Issue to x0 never marks a register pending
        IssueLongE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        expect_out("issue_x0", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b1);
        tick();
        idle();
        expect_out("x0_not_busy", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b1);
        tick();

        rst = 1'b0;
        #1;
        expect_out("err_cleared", 2'b00, 2'b00, CTL_NONE, 1'b0, 1'b0);
        tick();
        rst = 1'b1;

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
